// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio parameters and I2S receiver state type
//
// Purpose: default word/slot widths, bit-counter sizing and the receiver
// state enum shared by the I2S receiver files.
// Ports: none (package).

package audio_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;

  // Bit counter saturates at 63, so 6 bits cover any legal slot length.
  localparam int               CNT_W   = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_e;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 6'd1;
  endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// rtl/i2s_rx_if.sv - sample-pair handshake bundle between I2S receiver and consumer
//
// Purpose: groups the presented stereo pair and its valid/ready handshake.
// Signals:
//   sample_l     left word of the presented pair
//   sample_r     right word of the presented pair
//   sample_valid a pair is presented, held until accepted
//   sample_ready consumer accepts when sample_valid && sample_ready
// Modports: master = receiver side, slave = consumer side.

interface i2s_rx_if #(
  parameter int DATA_W = audio_pkg::DATA_W_DEF
) ();

  logic [DATA_W-1:0] sample_l;
  logic [DATA_W-1:0] sample_r;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_sync.sv
// rtl/i2s_sync.sv - two-flop synchronizer with rising-edge detect for one I2S pin
//
// Purpose: brings one asynchronous I2S input into the clk domain.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset, all flops clear to 0
//   in_i     asynchronous pin
//   level_o  synchronized level
//   rise_o   one-cycle pulse when the synchronized level goes 0 -> 1

module i2s_sync (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver presenting left/right sample pairs with a valid/ready handshake
//
// Purpose: deserializes an I2S stream (MSB first, one-bit delay after each
// lrck edge) into DATA_W-bit left/right words and presents complete pairs.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i2s_sclk     asynchronous bit clock (at most clk/8)
//   i2s_lrck     asynchronous word select, 0 = left, 1 = right
//   i2s_sdin     asynchronous serial data
//   smp          pair output bundle (sample_l/sample_r/sample_valid/sample_ready)
//   overrun      sticky: a completed pair was dropped while one was pending
//   frame_err    one-cycle pulse: a slot length differed from SLOT_W

module i2s_rx
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i2s_sclk,
  input  logic     i2s_lrck,
  input  logic     i2s_sdin,
  i2s_rx_if.master smp,
  output logic     overrun,
  output logic     frame_err
);

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_W - 1);

  logic sclk_rise;
  logic lrck_s;
  logic sdin_s;
  logic sclk_level_unused;
  logic lrck_rise_unused;
  logic sdin_rise_unused;

  i2s_sync u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .in_i    (i2s_sclk),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise)
  );

  i2s_sync u_sync_lrck (
    .clk     (clk),
    .rst     (rst),
    .in_i    (i2s_lrck),
    .level_o (lrck_s),
    .rise_o  (lrck_rise_unused)
  );

  i2s_sync u_sync_sdin (
    .clk     (clk),
    .rst     (rst),
    .in_i    (i2s_sdin),
    .level_o (sdin_s),
    .rise_o  (sdin_rise_unused)
  );

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              lrck_prev_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] left_hold_q;
  logic              left_ok_q;
  logic [DATA_W-1:0] sample_l_q;
  logic [DATA_W-1:0] sample_r_q;
  logic              valid_q;
  logic              overrun_q;
  logic              frame_err_q;

  logic              boundary;
  logic              in_slot;
  logic              do_shift;
  logic              word_done;
  logic [DATA_W-1:0] word_d;
  logic              left_done;
  logic              pair_form;
  logic              slot_err;
  logic              handshake;

  always_comb begin
    // lrck is judged against its value at the previous rise event, so an
    // lrck change only counts when the codec clocks it in.
    boundary  = sclk_rise && (lrck_s != lrck_prev_q);
    in_slot   = (state_q != SYNC);
    do_shift  = sclk_rise && !boundary && in_slot && (cnt_q <= DATA_LAST);
    word_done = do_shift && (cnt_q == DATA_LAST);
    word_d    = {shift_q[DATA_W-2:0], sdin_s};
    left_done = word_done && (state_q == LEFT);
    pair_form = word_done && (state_q == RIGHT) && left_ok_q;
    slot_err  = boundary && in_slot && (cnt_q != SLOT_LAST);
    handshake = valid_q && smp.sample_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      lrck_prev_q <= 1'b0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      sample_l_q  <= '0;
      sample_r_q  <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= slot_err;

      if (sclk_rise) begin
        lrck_prev_q <= lrck_s;
      end

      case (state_q)
        SYNC:    if (boundary && !lrck_s) state_q <= LEFT;
        LEFT:    if (boundary && lrck_s)  state_q <= RIGHT;
        RIGHT:   if (boundary && !lrck_s) state_q <= LEFT;
        default: state_q <= SYNC;
      endcase

      // The boundary rise carries the previous word's trailing bit, so it
      // only restarts the count; data bits follow from the next rise.
      if (boundary) begin
        cnt_q <= '0;
      end else if (sclk_rise) begin
        cnt_q <= cnt_sat_inc(cnt_q);
      end

      if (do_shift) begin
        shift_q <= word_d;
      end

      if (left_done) begin
        left_hold_q <= word_d;
      end

      if (slot_err || pair_form) begin
        left_ok_q <= 1'b0;
      end else if (left_done) begin
        left_ok_q <= 1'b1;
      end

      // A pending, unaccepted pair is never overwritten; an accepted one
      // can be replaced in the same edge without a valid gap.
      if (pair_form) begin
        if (valid_q && !smp.sample_ready) begin
          overrun_q <= 1'b1;
        end else begin
          sample_l_q <= left_hold_q;
          sample_r_q <= word_d;
          valid_q    <= 1'b1;
        end
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign smp.sample_l     = sample_l_q;
  assign smp.sample_r     = sample_r_q;
  assign smp.sample_valid = valid_q;
  assign overrun          = overrun_q;
  assign frame_err        = frame_err_q;

endmodule
